// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the up/down counter pair: default width and count direction.
package up_down_counter_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } count_dir_t;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_core.sv
// Free-running WIDTH-bit counter; direction fixed at elaboration, async active-low clear.
module counter_core
  import up_down_counter_pkg::*;
#(
  parameter int         WIDTH = COUNT_W,
  parameter count_dir_t DIR   = DIR_UP
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  // Adding all-ones is a decrement modulo 2^WIDTH, so one adder serves both directions.
  localparam logic [WIDTH-1:0] STEP = (DIR == DIR_UP) ? WIDTH'(1) : {WIDTH{1'b1}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count + STEP;
    end
  end

endmodule : counter_core

// File: rtl/up_down_counter.sv
// Up/down counter pair sharing clock and reset; counter_1 counts up, counter_2 counts down.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] counter_1,
  output logic [WIDTH-1:0] counter_2
);

  counter_core #(
    .WIDTH (WIDTH),
    .DIR   (DIR_UP)
  ) u_count_up (
    .clock (clock),
    .reset (reset),
    .count (counter_1)
  );

  counter_core #(
    .WIDTH (WIDTH),
    .DIR   (DIR_DOWN)
  ) u_count_down (
    .clock (clock),
    .reset (reset),
    .count (counter_2)
  );

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed steps plus randomized run lengths and resets.
module tb_up_down_counter;
  import up_down_counter_pkg::*;

  localparam int W   = COUNT_W;
  localparam int MOD = 1 << W;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] counter_1;
  logic [W-1:0] counter_2;

  int half     = 5;
  int n_checks = 0;
  int n_fail   = 0;
  int n_edges  = 0;

  always #(half) clock = ~clock;

  up_down_counter #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .counter_1 (counter_1),
    .counter_2 (counter_2)
  );

  // Reference: after n edges since reset, up = n mod 2^W and down = -n mod 2^W.
  function automatic logic [W-1:0] ref_up(input int n);
    return W'(n % MOD);
  endfunction

  function automatic logic [W-1:0] ref_down(input int n);
    return W'((MOD - (n % MOD)) % MOD);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [W-1:0] sum;
    sum = counter_1 + counter_2;
    chk($sformatf("%s up n=%0d", tag, n_edges), counter_1, ref_up(n_edges));
    chk($sformatf("%s down n=%0d", tag, n_edges), counter_2, ref_down(n_edges));
    chk($sformatf("%s invariant n=%0d", tag, n_edges), sum, '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " up zero"}, counter_1, '0);
    chk({tag, " down zero"}, counter_2, '0);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    n_edges++;
    @(negedge clock);
    chk_model(tag);
  endtask

  initial begin
    int k;
    int hold;

    // Reset hold across several clock edges.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_zero("reset_assert");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk_zero($sformatf("reset_hold%0d", i));
    end

    // Release between edges, then first three edges.
    reset   = 1'b1;
    n_edges = 0;
    step("release");
    chk("first_edge up", counter_1, 4'h1);
    chk("first_edge down", counter_2, 4'hF);
    step("release");
    step("release");
    chk("third_edge up", counter_1, 4'h3);
    chk("third_edge down", counter_2, 4'hD);

    // Complete one full period with both wraps.
    while (n_edges < 15) step("period");
    chk("edge15 up", counter_1, 4'hF);
    chk("edge15 down", counter_2, 4'h1);
    step("period");
    chk("edge16 up wrap", counter_1, 4'h0);
    chk("edge16 down", counter_2, 4'h0);

    // Down wrap immediately out of reset.
    reset = 1'b0;
    #1 chk_zero("down_wrap_reset");
    reset   = 1'b1;
    n_edges = 0;
    step("down_wrap");
    chk("down_wrap down", counter_2, 4'hF);
    chk("down_wrap up", counter_1, 4'h1);

    // Asynchronous reset midway between edges after 7 counts.
    while (n_edges < 7) step("mid");
    chk("mid7 up", counter_1, 4'h7);
    chk("mid7 down", counter_2, 4'h9);
    #2 reset = 1'b0;
    #1 chk_zero("mid_async");
    @(posedge clock);
    #1 chk_zero("mid_held");
    @(negedge clock);
    reset   = 1'b1;
    n_edges = 0;
    step("mid_restart");
    chk("mid_restart up", counter_1, 4'h1);
    chk("mid_restart down", counter_2, 4'hF);

    // Randomized run lengths and reset placement.
    for (int it = 0; it < 8; it++) begin
      k = int'($urandom_range(1, 40));
      repeat (k) step($sformatf("rand%0d", it));
      #($urandom_range(1, 3)) reset = 1'b0;
      #1 chk_zero($sformatf("rand%0d_async", it));
      hold = int'($urandom_range(1, 3));
      repeat (hold) begin
        @(negedge clock);
        chk_zero($sformatf("rand%0d_hold", it));
      end
      reset   = 1'b1;
      n_edges = 0;
    end

    // Long run at a 2-unit clock period.
    reset = 1'b0;
    half  = 1;
    #1 chk_zero("long_reset");
    @(posedge clock);
    @(negedge clock);
    reset   = 1'b1;
    n_edges = 0;
    repeat (50) step("long");
    chk("long_end up", counter_1, 4'h2);
    chk("long_end down", counter_2, 4'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
